// File: rtl/blade_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module : blade_stage_ctrl
// Brief  : Resilient bundled-data stage controller with an error-detection
//          window and a penalty cycle insertion before the right request.
//          Optional macro BLADE_ERR_CNT_EN adds err_cnt / err_last outputs.
// Rev    : 1.0  initial release
// ============================================================================
module blade_stage_ctrl #(
    parameter int NCH     = 2,
    parameter int ERR_WIN = 3,
    parameter int PENALTY = 2,
    parameter int CW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           lreq,
    output logic           lack,
    output logic           rreq,
    input  logic           rack,
    input  logic [NCH-1:0] err,
    input  logic [NCH-1:0] err_mask,
    output logic           latch_en,
    output logic           sample,
    output logic           err_flag
`ifdef BLADE_ERR_CNT_EN
    ,
    output logic [CW-1:0]  err_cnt,
    output logic [NCH-1:0] err_last
`endif
);

    localparam logic [5:0] IDLE  = 6'b000001;
    localparam logic [5:0] CAPT  = 6'b000010;
    localparam logic [5:0] CHECK = 6'b000100;
    localparam logic [5:0] PEN   = 6'b001000;
    localparam logic [5:0] REQ   = 6'b010000;
    localparam logic [5:0] RTZ   = 6'b100000;

    localparam logic [7:0] WIN_LAST = 8'(ERR_WIN - 1);
    localparam logic [7:0] PEN_LAST = 8'(PENALTY - 1);

    generate
        if (NCH < 1 || ERR_WIN < 1 || ERR_WIN > 255 ||
            PENALTY < 1 || PENALTY > 255 || CW < 1) begin : g_param_err
            $error("blade_stage_ctrl: parameter out of range");
        end
    endgenerate

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;
    logic [5:0]     r_state;
    logic [5:0]     w_next;
    logic [7:0]     r_wcnt;
    logic [7:0]     r_pcnt;
    logic           r_lack;
    logic           r_err_seen;
    logic           r_err_flag;
    logic [NCH-1:0] w_err_vec;
    logic           w_err_now;
    logic           w_win_end;

    // Assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_err_vec = err & err_mask;
    assign w_err_now = |w_err_vec;
    assign w_win_end = (r_state == CHECK) && (r_wcnt == WIN_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (lreq && !r_lack && !rack) w_next = CAPT;
            CAPT:    w_next = CHECK;
            CHECK:   if (w_win_end) w_next = (r_err_seen || w_err_now) ? PEN : REQ;
            PEN:     if (r_pcnt == PEN_LAST) w_next = REQ;
            REQ:     if (rack) w_next = RTZ;
            RTZ:     if (!rack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_wcnt     <= 8'd0;
            r_pcnt     <= 8'd0;
            r_lack     <= 1'b0;
            r_err_seen <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            r_state <= w_next;

            // The left return-to-zero may overlap any later state.
            if (r_state == CAPT) begin
                r_lack <= 1'b1;
            end else if (!lreq && r_lack) begin
                r_lack <= 1'b0;
            end

            if (r_state == CAPT) begin
                r_wcnt     <= 8'd0;
                r_err_seen <= 1'b0;
            end else if (r_state == CHECK) begin
                r_wcnt     <= r_wcnt + 8'd1;
                r_err_seen <= r_err_seen | w_err_now;
                if (w_win_end) begin
                    r_err_flag <= r_err_seen | w_err_now;
                end
            end

            if (r_state == CHECK) begin
                r_pcnt <= 8'd0;
            end else if (r_state == PEN) begin
                r_pcnt <= r_pcnt + 8'd1;
            end
        end
    end

    assign lack     = r_lack;
    assign err_flag = r_err_flag;
    assign latch_en = (r_state == CAPT);
    assign sample   = (r_state == CHECK);
    assign rreq     = (r_state == REQ);

`ifdef BLADE_ERR_CNT_EN
    logic [NCH-1:0] r_err_acc;
    logic [NCH-1:0] r_err_last;
    logic [CW-1:0]  r_err_cnt;
    logic           w_to_pen;

    assign w_to_pen = (r_state == CHECK) && (w_next == PEN);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_err_acc  <= '0;
            r_err_last <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (r_state == CAPT) begin
                r_err_acc <= '0;
            end else if (r_state == CHECK) begin
                r_err_acc <= r_err_acc | w_err_vec;
            end
            if (w_to_pen) begin
                r_err_last <= r_err_acc | w_err_vec;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CW'(1);
                end
            end
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_last = r_err_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blade_stage_ctrl.sv
`default_nettype none
// Bench for blade_stage_ctrl: token-level expectations derived from the
// window/penalty latency rules, with directed and randomized tokens.
module tb_blade_stage_ctrl;

    localparam int NCH = 2;
    localparam int W   = 3;
    localparam int P   = 2;
`ifdef BLADE_ERR_CNT_EN
    localparam int CW  = 2;
`else
    localparam int CW  = 8;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           lreq = 1'b0;
    logic           rack = 1'b0;
    logic [NCH-1:0] err = '0;
    logic [NCH-1:0] err_mask = '1;
    logic           lack, rreq, latch_en, sample, err_flag;
`ifdef BLADE_ERR_CNT_EN
    logic [CW-1:0]  err_cnt;
    logic [NCH-1:0] err_last;
`endif

    int             checks = 0;
    int             errors = 0;
    logic           exp_flag = 1'b0;
    int             exp_cnt = 0;
    logic [NCH-1:0] exp_last = '0;
    logic [NCH-1:0] pat [16];

    always #5 clk = ~clk;

    blade_stage_ctrl #(.NCH(NCH), .ERR_WIN(W), .PENALTY(P), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .lreq     (lreq),
        .lack     (lack),
        .rreq     (rreq),
        .rack     (rack),
        .err      (err),
        .err_mask (err_mask),
        .latch_en (latch_en),
        .sample   (sample),
        .err_flag (err_flag)
`ifdef BLADE_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt),
        .err_last (err_last)
`endif
    );

    task automatic clear_pat();
        for (int i = 0; i < 16; i++) pat[i] = '0;
    endtask

    // One token; cycle k is the interval that ends at edge k, edge 0 samples lreq.
    task automatic run_token(input logic [NCH-1:0] mask, input int dly,
                             input int lfall, input int rtz, input bit hold);
        logic [NCH-1:0] win_or;
        logic           has_err;
        int             r_cyc;
        int             k_end;
        logic           e_v;
        win_or = '0;
        for (int c = 2; c <= W + 1; c++) win_or = win_or | (pat[c] & mask);
        has_err = |win_or;
        r_cyc   = W + 2 + (has_err ? P : 0);
        k_end   = hold ? r_cyc + dly + 2 : r_cyc + dly + rtz + 2;
        err_mask = mask;
        @(negedge clk);
        lreq = 1'b1;
        err  = pat[0];
        for (int k = 1; k <= k_end; k++) begin
            @(negedge clk);
            e_v = (k == 1);
            checks++;
            if (latch_en !== e_v) begin errors++; $display("FAIL latch_en k=%0d got %b exp %b", k, latch_en, e_v); end
            e_v = (k >= 2 && k <= W + 1);
            checks++;
            if (sample !== e_v) begin errors++; $display("FAIL sample k=%0d got %b exp %b", k, sample, e_v); end
            e_v = (k >= r_cyc && k <= r_cyc + dly);
            checks++;
            if (rreq !== e_v) begin errors++; $display("FAIL rreq k=%0d got %b exp %b", k, rreq, e_v); end
            e_v = (k >= 2 && k <= lfall);
            checks++;
            if (lack !== e_v) begin errors++; $display("FAIL lack k=%0d got %b exp %b", k, lack, e_v); end
            e_v = (k <= W + 1) ? exp_flag : has_err;
            checks++;
            if (err_flag !== e_v) begin errors++; $display("FAIL err_flag k=%0d got %b exp %b", k, err_flag, e_v); end
            err = (k < 16) ? pat[k] : '0;
            if (k == lfall) lreq = 1'b0;
            if (k == r_cyc + dly) rack = 1'b1;
            if (!hold && k == r_cyc + dly + 1 + rtz) rack = 1'b0;
        end
        err = '0;
        exp_flag = has_err;
        if (has_err) begin
            exp_last = win_or;
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
`ifdef BLADE_ERR_CNT_EN
        checks++;
        if (err_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL err_cnt got %0d exp %0d", err_cnt, exp_cnt); end
        checks++;
        if (err_last !== exp_last) begin errors++; $display("FAIL err_last got %b exp %b", err_last, exp_last); end
`endif
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({lack, rreq, latch_en, sample, err_flag} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b exp 00000", {lack, rreq, latch_en, sample, err_flag});
        end
`ifdef BLADE_ERR_CNT_EN
        checks++;
        if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
`endif
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_no_error();
        clear_pat();
        run_token(2'b11, 0, 2, 0, 1'b0);
    endtask

    task automatic test_error_mid();
        clear_pat();
        pat[3] = 2'b01;
        run_token(2'b11, 1, 3, 1, 1'b0);
    endtask

    task automatic test_window_edges();
        clear_pat();
        pat[4] = 2'b10;
        run_token(2'b11, 0, 2, 0, 1'b0);
        clear_pat();
        pat[5] = 2'b10;
        run_token(2'b11, 2, 4, 2, 1'b0);
    endtask

    task automatic test_masked();
        for (int i = 0; i < 16; i++) pat[i] = 2'b10;
        run_token(2'b01, 0, 2, 0, 1'b0);
        clear_pat();
        pat[2] = 2'b11;
        run_token(2'b00, 0, 2, 0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int t = 0; t < 5; t++) begin
            clear_pat();
            pat[2 + (t % W)] = 2'(1 + (t % 3));
            run_token(2'b11, t % 3, 2 + (t % 3), t % 2, 1'b0);
        end
    endtask

    task automatic test_rack_hold();
        bit done;
        clear_pat();
        run_token(2'b11, 0, 2, 0, 1'b1);
        @(negedge clk);
        lreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (latch_en !== 1'b0) begin errors++; $display("FAIL hold_no_capt i=%0d got %b exp 0", i, latch_en); end
        end
        rack = 1'b0;
        @(negedge clk);
        checks++;
        if (latch_en !== 1'b0) begin errors++; $display("FAIL hold_idle got %b exp 0", latch_en); end
        @(negedge clk);
        checks++;
        if (latch_en !== 1'b1) begin errors++; $display("FAIL hold_capt got %b exp 1", latch_en); end
        done = 1'b0;
        for (int k = 2; k <= 30 && !done; k++) begin
            @(negedge clk);
            if (k == 2) lreq = 1'b0;
            if (rack) begin
                if (!rreq) begin rack = 1'b0; done = 1'b1; end
            end else if (rreq) begin
                checks++;
                if (k != W + 2) begin errors++; $display("FAIL hold_rreq_cycle got %0d exp %0d", k, W + 2); end
                rack = 1'b1;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL hold_timeout got 0 exp 1"); end
        repeat (2) @(negedge clk);
        exp_flag = 1'b0;
    endtask

    task automatic test_reset_pen();
        clear_pat();
        pat[2] = 2'b01;
        err_mask = 2'b11;
        @(negedge clk);
        lreq = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) err = pat[k];
        end
        checks++;
        if ({rreq, lack, err_flag} !== 3'b011) begin
            errors++; $display("FAIL pen_state got %b exp 011", {rreq, lack, err_flag});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({lack, rreq, latch_en, sample, err_flag} !== 5'b0) begin
            errors++; $display("FAIL async_reset got %b exp 00000", {lack, rreq, latch_en, sample, err_flag});
        end
        err  = '0;
        lreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        exp_flag = 1'b0;
        exp_cnt  = 0;
        exp_last = '0;
        clear_pat();
        run_token(2'b11, 0, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 16; i++)
                pat[i] = ($urandom_range(0, 2) == 0) ? NCH'($urandom_range(1, 3)) : '0;
            run_token(NCH'($urandom_range(0, 3)), $urandom_range(0, 2),
                      $urandom_range(2, 5), $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_no_error();
        test_error_mid();
        test_window_edges();
        test_masked();
        test_saturation();
        test_rack_hold();
        test_reset_pen();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
